imem_loader: RTL



---
 rtl/imem_loader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer.
//
// Takes a framed byte stream (0xA5 sync, 16-bit little-endian word count N, 4*N payload bytes,
// one XOR checksum byte), assembles little-endian 32-bit words and issues one-cycle write
// strobes into instruction memory starting at TEXT_BASE. The CPU is held until a frame has
// loaded completely with a matching checksum.
//
// Optional feature (compile-time macro IMEM_LOADER_TIMEOUT_EN): inter-byte timeout. When
// defined, a frame that stalls for TIMEOUT_CYCLES cycles mid-frame is aborted to the error state.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   iByte         in   stream byte
//   iByteValid    in   iByte valid this cycle
//   oByteReady    out  loader accepts a byte this cycle
//   oWriteEnable  out  one-cycle instruction memory write strobe
//   oWriteAddress out  byte address of the word being written
//   oWriteData    out  assembled instruction word
//   oCpuHold      out  1 = keep the pipeline from fetching
//   oDone         out  last frame loaded and verified
//   oError        out  last frame aborted
//   oWordCount    out  words written in the current or last frame
module imem_loader #(
   parameter logic [31:0] TEXT_BASE      = 32'h0040_0000,
   parameter int unsigned MAX_WORDS      = 1024,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [7:0]  iByte,
   input  logic        iByteValid,
   output logic        oByteReady,
   output logic        oWriteEnable,
   output logic [31:0] oWriteAddress,
   output logic [31:0] oWriteData,
   output logic        oCpuHold,
   output logic        oDone,
   output logic        oError,
   output logic [15:0] oWordCount
);

   typedef enum logic [2:0] {
      StIdle,
      StLenLo,
      StLenHi,
      StData,
      StCheck,
      StDone,
      StError
   } state_e;

   state_e state_q, state_d;

   logic        ready_q;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] len_q, len_d;
   logic [7:0]  csum_q, csum_d;
   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] word_asm_q, word_asm_d;   // bytes 0..2 of the word in flight
   logic        wr_en_q, wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
   logic [15:0] word_count_q, word_count_d;  // doubles as the write word index

   logic        accept;
   logic        is_sync;
   logic [15:0] len_full;
   logic        last_word;
   logic        tmo_expired;

   assign accept    = iByteValid & ready_q;
   assign is_sync   = (iByte == 8'hA5);
   assign len_full  = {iByte, len_lo_q};
   assign last_word = ((word_count_q + 16'd1) == len_q);

`ifdef IMEM_LOADER_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic        tmo_active;

   always_comb begin
      tmo_active  = (state_q == StLenLo) || (state_q == StLenHi) ||
                    (state_q == StData)  || (state_q == StCheck);
      tmo_expired = tmo_active && !accept && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
      tmo_d       = (accept || !tmo_active) ? 32'd0 : tmo_q + 32'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tmo_q <= 32'd0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   logic unused_timeout;

   assign tmo_expired    = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle, StDone, StError: begin
            if (accept && is_sync) state_d = StLenLo;
         end
         StLenLo: begin
            if (accept) state_d = StLenHi;
         end
         StLenHi: begin
            if (accept) begin
               if (32'(len_full) > MAX_WORDS) begin
                  state_d = StError;
               end else if (len_full == 16'd0) begin
                  state_d = StCheck;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept && (byte_idx_q == 2'd3) && last_word) state_d = StCheck;
         end
         StCheck: begin
            if (accept) state_d = (iByte == csum_q) ? StDone : StError;
         end
         default: state_d = StIdle;
      endcase
      if (tmo_expired) state_d = StError;
   end

   // Datapath next-state: checksum, word assembly and write strobe generation
   always_comb begin
      len_lo_d     = len_lo_q;
      len_d        = len_q;
      csum_d       = csum_q;
      byte_idx_d   = byte_idx_q;
      word_asm_d   = word_asm_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      word_count_d = word_count_q;
      if (accept) begin
         case (state_q)
            StIdle, StDone, StError: begin
               if (is_sync) begin
                  csum_d       = 8'h00;
                  byte_idx_d   = 2'd0;
                  word_count_d = 16'd0;
               end
            end
            StLenLo: len_lo_d = iByte;
            StLenHi: len_d    = len_full;
            StData: begin
               csum_d     = csum_q ^ iByte;
               byte_idx_d = byte_idx_q + 2'd1;
               unique case (byte_idx_q)
                  2'd0: word_asm_d[7:0]   = iByte;
                  2'd1: word_asm_d[15:8]  = iByte;
                  2'd2: word_asm_d[23:16] = iByte;
                  2'd3: begin
                     // Word complete: strobe goes out on the following cycle.
                     wr_en_d      = 1'b1;
                     wr_data_d    = {iByte, word_asm_q};
                     wr_addr_d    = TEXT_BASE + {14'd0, word_count_q, 2'b00};
                     word_count_d = word_count_q + 16'd1;
                  end
                  default: ;
               endcase
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ready_q      <= 1'b0;
         len_lo_q     <= 8'h00;
         len_q        <= 16'd0;
         csum_q       <= 8'h00;
         byte_idx_q   <= 2'd0;
         word_asm_q   <= 24'd0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= TEXT_BASE;
         wr_data_q    <= 32'd0;
         word_count_q <= 16'd0;
      end else begin
         ready_q      <= 1'b1;
         len_lo_q     <= len_lo_d;
         len_q        <= len_d;
         csum_q       <= csum_d;
         byte_idx_q   <= byte_idx_d;
         word_asm_q   <= word_asm_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         word_count_q <= word_count_d;
      end
   end

   // Outputs
   always_comb begin
      oByteReady    = ready_q;
      oWriteEnable  = wr_en_q;
      oWriteAddress = wr_addr_q;
      oWriteData    = wr_data_q;
      oWordCount    = word_count_q;
      oDone         = (state_q == StDone);
      oError        = (state_q == StError);
      oCpuHold      = (state_q != StDone);
   end

endmodule
